// File: rtl/pad_mux_sequencer.sv
// -----------------------------------------------------------------------------
// pad_mux_sequencer
//
// Owns the per-pad mux/config shadow registers that drive the pad controller
// and applies update requests from two requesters (port 0 = SoC control,
// port 1 = debug/boot). A mux change is made glitch-safe: the pad is isolated,
// switched, held isolated to settle, then released. A config-only change
// (same mux value) skips isolation.
//
// Optional feature macro: PAD_SEQ_LOCK_EN
//   defined   : lock_set_i sets a sticky lock (cleared only by rst_i); while
//               locked, port 0 requests are accepted but rejected with err_o.
//   undefined : lock_set_i is ignored; err_o only flags an out-of-range index.
//
// Ports
//   clk_i        single clock
//   rst_i        synchronous reset, active-high
//   req_valid_i  [2]             per-port request valid
//   req_ready_o  [2]             per-port accept, one cycle on grant
//   req_idx_i    [2*IDX_W]       pad index, port p at [p*IDX_W +: IDX_W]
//   req_mux_i    [2*MUX_W]       new mux value per port
//   req_cfg_i    [2*CFG_W]       new cfg value per port
//   lock_set_i                   pulse: set sticky lock (PAD_SEQ_LOCK_EN only)
//   busy_o                       high whenever the sequencer is not idle
//   done_o                       one-cycle completion pulse
//   done_id_o                    port that owned the completed request
//   err_o                        with done_o: request rejected, nothing written
//   pad_mux_o    [N_PADS*MUX_W]  mux shadow, pad k at [k*MUX_W +: MUX_W]
//   pad_cfg_o    [N_PADS*CFG_W]  cfg shadow, pad k at [k*CFG_W +: CFG_W]
//   pad_iso_o    [N_PADS]        per-pad isolation (at most one bit high)
// -----------------------------------------------------------------------------
module pad_mux_sequencer #(
  parameter int N_PADS        = 48,
  parameter int MUX_W         = 2,
  parameter int CFG_W         = 6,
  parameter int ISO_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int IDX_W         = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [2*IDX_W-1:0]        req_idx_i,
  input  logic [2*MUX_W-1:0]        req_mux_i,
  input  logic [2*CFG_W-1:0]        req_cfg_i,
  input  logic                      lock_set_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      done_id_o,
  output logic                      err_o,
  output logic [N_PADS*MUX_W-1:0]   pad_mux_o,
  output logic [N_PADS*CFG_W-1:0]   pad_cfg_o,
  output logic [N_PADS-1:0]         pad_iso_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISO    = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Down-counters hold (cycles - 1) so the last counted cycle is the one at 0.
  localparam logic [7:0]     ISO_LOAD    = 8'(ISO_CYCLES - 1);
  localparam logic [7:0]     SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W:0] N_PADS_EXT  = (IDX_W+1)'(N_PADS);

  // Control state (reset)
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       chg_q, chg_d;
  logic       last_q, last_d;

  // Latched request (data, no reset)
  logic [IDX_W-1:0] idx_q;
  logic [MUX_W-1:0] mux_new_q;
  logic [CFG_W-1:0] cfg_new_q;
  logic             gnt_q;

  // Shadow registers
  logic [MUX_W-1:0] mux_sh [N_PADS];
  logic [CFG_W-1:0] cfg_sh [N_PADS];

  // Arbitration and request decode
  logic             gnt_any;
  logic             gnt_sel;
  logic             take;
  logic [IDX_W-1:0] sel_idx;
  logic [MUX_W-1:0] sel_mux;
  logic [CFG_W-1:0] sel_cfg;
  logic             in_range;
  logic [MUX_W-1:0] cur_mux;
  logic             lock_block;
  logic             iso_on;

  assign gnt_any = |req_valid_i;
  // Both requesting: the port that was not served last wins.
  assign gnt_sel = (&req_valid_i) ? ~last_q : req_valid_i[1];

  assign sel_idx = gnt_sel ? req_idx_i[IDX_W +: IDX_W] : req_idx_i[0 +: IDX_W];
  assign sel_mux = gnt_sel ? req_mux_i[MUX_W +: MUX_W] : req_mux_i[0 +: MUX_W];
  assign sel_cfg = gnt_sel ? req_cfg_i[CFG_W +: CFG_W] : req_cfg_i[0 +: CFG_W];
  assign in_range = ({1'b0, sel_idx} < N_PADS_EXT);

`ifdef PAD_SEQ_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
    end else if (lock_set_i) begin
      lock_q <= 1'b1;
    end
  end

  // Lock only fences the SoC port; debug/boot keeps full access.
  assign lock_block = lock_q && !gnt_sel;
`else
  logic unused_lock;
  assign unused_lock = lock_set_i;
  assign lock_block  = 1'b0;
`endif

  // Current mux of the requested pad; only meaningful when in_range.
  always_comb begin
    cur_mux = '0;
    for (int k = 0; k < N_PADS; k++) begin
      if (sel_idx == IDX_W'(k)) begin
        cur_mux = mux_sh[k];
      end
    end
  end

  // Ready is a combinational grant; reset masks it so nothing is accepted
  // in a cycle whose effect is discarded.
  always_comb begin
    req_ready_o = 2'b00;
    if (state_q == S_IDLE && !rst_i && gnt_any) begin
      req_ready_o = gnt_sel ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    chg_d   = chg_q;
    last_d  = last_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          take   = 1'b1;
          last_d = gnt_sel;
          if (!in_range || lock_block) begin
            err_d   = 1'b1;
            chg_d   = 1'b0;
            state_d = S_DONE;
          end else if (sel_mux != cur_mux) begin
            err_d   = 1'b0;
            chg_d   = 1'b1;
            cnt_d   = ISO_LOAD;
            state_d = S_ISO;
          end else begin
            err_d   = 1'b0;
            chg_d   = 1'b0;
            state_d = S_APPLY;
          end
        end
      end
      S_ISO: begin
        if (cnt_q == 8'd0) begin
          state_d = S_APPLY;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_APPLY: begin
        if (chg_q) begin
          cnt_d   = SETTLE_LOAD;
          state_d = S_SETTLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      chg_q   <= 1'b0;
      last_q  <= 1'b1;  // port 0 wins the first contended grant
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      chg_q   <= chg_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (take) begin
      idx_q     <= sel_idx;
      mux_new_q <= sel_mux;
      cfg_new_q <= sel_cfg;
      gnt_q     <= gnt_sel;
    end
  end

  // Shadow write lands at the end of APPLY; only the addressed pad changes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_PADS; k++) begin
        mux_sh[k] <= '0;
        cfg_sh[k] <= '0;
      end
    end else if (state_q == S_APPLY) begin
      for (int k = 0; k < N_PADS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          mux_sh[k] <= mux_new_q;
          cfg_sh[k] <= cfg_new_q;
        end
      end
    end
  end

  // Isolation covers ISO, the switching APPLY cycle and SETTLE of a mux change.
  assign iso_on = (state_q == S_ISO) || (state_q == S_SETTLE) ||
                  (state_q == S_APPLY && chg_q);

  always_comb begin
    pad_iso_o = '0;
    for (int k = 0; k < N_PADS; k++) begin
      if (iso_on && idx_q == IDX_W'(k)) begin
        pad_iso_o[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_PADS; k++) begin : g_flat
    assign pad_mux_o[k*MUX_W +: MUX_W] = mux_sh[k];
    assign pad_cfg_o[k*CFG_W +: CFG_W] = cfg_sh[k];
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign done_id_o = done_o && gnt_q;
  assign err_o     = done_o && err_q;

endmodule

// File: tb/tb_pad_mux_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pad_mux_sequencer
// Scoreboard bench: the grant observer computes each request's expected
// outcome (owner, error, latency, resulting shadow image, isolation window)
// from a per-pad array model and queues it; the same negedge process pops and
// compares when done_o appears. Directed cases first, then random traffic.
// -----------------------------------------------------------------------------
module tb_pad_mux_sequencer;

  localparam int N_PADS        = 48;
  localparam int MUX_W         = 2;
  localparam int CFG_W         = 6;
  localparam int ISO_CYCLES    = 2;
  localparam int SETTLE_CYCLES = 4;
  localparam int IDX_W         = 6;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic [1:0]       vld_a;
  logic [IDX_W-1:0] idx_a [2];
  logic [MUX_W-1:0] mux_a [2];
  logic [CFG_W-1:0] cfg_a [2];
  logic             lock_set_i;

  logic [1:0]              req_valid_i;
  logic [1:0]              req_ready_o;
  logic [2*IDX_W-1:0]      req_idx_i;
  logic [2*MUX_W-1:0]      req_mux_i;
  logic [2*CFG_W-1:0]      req_cfg_i;
  logic                    busy_o, done_o, done_id_o, err_o;
  logic [N_PADS*MUX_W-1:0] pad_mux_o;
  logic [N_PADS*CFG_W-1:0] pad_cfg_o;
  logic [N_PADS-1:0]       pad_iso_o;

  assign req_valid_i = vld_a;
  assign req_idx_i   = {idx_a[1], idx_a[0]};
  assign req_mux_i   = {mux_a[1], mux_a[0]};
  assign req_cfg_i   = {cfg_a[1], cfg_a[0]};

  pad_mux_sequencer #(
    .N_PADS(N_PADS), .MUX_W(MUX_W), .CFG_W(CFG_W),
    .ISO_CYCLES(ISO_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES), .IDX_W(IDX_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_idx_i(req_idx_i), .req_mux_i(req_mux_i), .req_cfg_i(req_cfg_i),
    .lock_set_i(lock_set_i),
    .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o), .err_o(err_o),
    .pad_mux_o(pad_mux_o), .pad_cfg_o(pad_cfg_o), .pad_iso_o(pad_iso_o)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                      id;
    bit                      err;
    logic [N_PADS*MUX_W-1:0] mb;
    logic [N_PADS*CFG_W-1:0] cb;
    int                      tg;
    int                      lat;
  } exp_t;
  exp_t sbq[$];

  // Reference model
  int mux_m [N_PADS];
  int cfg_m [N_PADS];
  bit last_m = 1'b1;
  bit lock_m = 1'b0;
  bit win_on = 1'b0;
  int iso_s, iso_e, iso_i;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s @cyc %0d", nm, cyc);
  endtask

  function automatic logic [N_PADS*MUX_W-1:0] mux_img();
    logic [N_PADS*MUX_W-1:0] r;
    for (int k = 0; k < N_PADS; k++) r[k*MUX_W +: MUX_W] = MUX_W'(mux_m[k]);
    return r;
  endfunction

  function automatic logic [N_PADS*CFG_W-1:0] cfg_img();
    logic [N_PADS*CFG_W-1:0] r;
    for (int k = 0; k < N_PADS; k++) r[k*CFG_W +: CFG_W] = CFG_W'(cfg_m[k]);
    return r;
  endfunction

  // Grant observer, isolation/ready checker and done monitor.
  always @(negedge clk) begin
    logic [1:0]        er;
    logic [N_PADS-1:0] ei;
    exp_t              e;
    int                g, idx;
    bit                xerr, chg;
    if (rst_i) begin
      sbq.delete();
      for (int k = 0; k < N_PADS; k++) begin mux_m[k] = 0; cfg_m[k] = 0; end
      last_m = 1'b1;
      lock_m = 1'b0;
      win_on = 1'b0;
    end else begin
      if (busy_o)                er = 2'b00;
      else if (vld_a == 2'b11)   er = last_m ? 2'b01 : 2'b10;
      else                       er = vld_a;
      chk("ready", req_ready_o, er);

      if (!busy_o) begin
        chk("idle_mux", pad_mux_o, mux_img());
        chk("idle_cfg", pad_cfg_o, cfg_img());
      end

      ei = '0;
      if (win_on && cyc >= iso_s && cyc <= iso_e) ei[iso_i] = 1'b1;
      chk("iso", pad_iso_o, ei);

      if (done_o) begin
        if (sbq.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          e = sbq.pop_front();
          chk("done_id", done_id_o, e.id);
          chk("done_err", err_o, e.err);
          chk("done_lat", cyc - e.tg, e.lat);
          chk("done_mux", pad_mux_o, e.mb);
          chk("done_cfg", pad_cfg_o, e.cb);
        end
      end else begin
        chk("err_no_done", err_o, 1'b0);
        if (sbq.size() > 0 && cyc - sbq[0].tg > 40) begin
          fail_now("done_timeout");
          e = sbq.pop_front();
        end
      end

      if (er != 2'b00) begin
        g    = er[1] ? 1 : 0;
        idx  = int'(idx_a[g]);
        xerr = (idx >= N_PADS) || (lock_m && g == 0);
        chg  = !xerr && (mux_m[idx] != int'(mux_a[g]));
        e.id  = g;
        e.err = xerr;
        e.tg  = cyc;
        e.lat = xerr ? 1 : (chg ? ISO_CYCLES + SETTLE_CYCLES + 2 : 2);
        if (chg) begin
          win_on = 1'b1;
          iso_s  = cyc + 1;
          iso_e  = cyc + ISO_CYCLES + SETTLE_CYCLES + 1;
          iso_i  = idx;
        end
        if (!xerr) begin
          mux_m[idx] = int'(mux_a[g]);
          cfg_m[idx] = int'(cfg_a[g]);
        end
        e.mb = mux_img();
        e.cb = cfg_img();
        sbq.push_back(e);
        last_m = g[0];
      end
`ifdef PAD_SEQ_LOCK_EN
      if (lock_set_i) lock_m = 1'b1;
`endif
    end
  end

  // Present a request on port p and hold it until granted. With keep=1
  // valid stays high so the caller can chain back-to-back requests.
  task automatic send(input int p, input int idx, input int mux, input int cfg, input bit keep);
    bit got = 1'b0;
    vld_a[p] = 1'b1;
    idx_a[p] = IDX_W'(idx);
    mux_a[p] = MUX_W'(mux);
    cfg_a[p] = CFG_W'(cfg);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (req_ready_o[p]) got = 1'b1;
    end
    if (!got) fail_now("grant_timeout");
    @(posedge clk);
    #1;
    if (!keep) vld_a[p] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (!busy_o && sbq.size() == 0) ok = 1'b1;
    end
    if (!ok) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic rand_port(input int p, input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 7)) : int'($urandom_range(40, 63));
      send(p, idx, int'($urandom_range(0, 3)), int'($urandom_range(0, 63)), i != n - 1);
    end
  endtask

  initial begin
    int nm;
    rst_i      = 1'b1;
    vld_a      = 2'b00;
    lock_set_i = 1'b0;
    for (int p = 0; p < 2; p++) begin idx_a[p] = '0; mux_a[p] = '0; cfg_a[p] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    @(negedge clk);
    chk("rst_mux", pad_mux_o, '0);
    chk("rst_cfg", pad_cfg_o, '0);
    chk("rst_iso", pad_iso_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_done_id", done_id_o, 1'b0);
    @(posedge clk);
    #1;

    // Config-only, mux change, out-of-range
    send(0, 5, 0, 'h2A, 1'b0);
    wait_idle();
    chk("pad5_cfg", pad_cfg_o[35:30], 6'h2A);
    send(1, 47, 3, 'h15, 1'b0);
    wait_idle();
    chk("pad47_mux", pad_mux_o[95:94], 2'b11);
    send(0, 50, 1, 'h3F, 1'b0);
    wait_idle();
    send(1, 63, 2, 'h01, 1'b0);
    wait_idle();

    // Contention on pads 3 and 4
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 3, i, 'h10 + i, i != 3);
      end
      begin
        for (int i = 0; i < 4; i++) send(1, 4, 3 - i, 'h20 + i, i != 3);
      end
    join
    wait_idle();

    // Reset while in SETTLE
    nm = (mux_m[10] + 1) % 4;
    send(0, 10, nm, 'h07, 1'b0);
    repeat (ISO_CYCLES + 2) @(posedge clk);
    #1;
    chk("busy_before_rst", busy_o, 1'b1);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_iso", pad_iso_o, '0);
    chk("midrst_mux", pad_mux_o, '0);
    chk("midrst_cfg", pad_cfg_o, '0);
    repeat (10) @(posedge clk);
    #1;

    // Lock pulse followed by the same write from each port
    lock_set_i = 1'b1;
    @(posedge clk);
    #1 lock_set_i = 1'b0;
    send(0, 12, 2, 'h11, 1'b0);
    wait_idle();
    send(1, 12, 2, 'h11, 1'b0);
    wait_idle();

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      fork
        rand_port(0, int'($urandom_range(0, 3)));
        rand_port(1, int'($urandom_range(0, 3)));
      join
      wait_idle();
    end

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout @cyc %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
